// File: rtl/bus_mux_arb.sv
// N-channel registered bus multiplexer with an internal fixed-priority or
// round-robin arbiter and a valid/ready handshake toward one consumer.
module bus_mux_arb #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int RR = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] din,
   output logic [N-1:0]   grant,
   output logic [W-1:0]   y,
   output logic           valid,
   input  logic           ready
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_r;
   logic [W-1:0]  y_r;
   logic          valid_r;

   logic          load_en_s;
   logic          any_req_s;
   logic [PW-1:0] start_s;
   logic [PW-1:0] winner_s;
   logic [PW-1:0] ptr_next_s;
   logic [N-1:0]  grant_s;
   logic [W-1:0]  y_next_s;

   assign load_en_s = !valid_r || ready;
   assign any_req_s = |req;

   // Winner search: scan offsets high to low so the nearest set bit from start wins.
   always_comb begin
      winner_s = '0;
      start_s  = (RR != 0) ? ptr_r : '0;
      for (int k = N - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(start_s) + k) % N;
         if (req[idx]) begin
            winner_s = PW'(idx);
         end else begin
            winner_s = winner_s;
         end
      end
   end

   // Rotation pointer successor and selected data word.
   always_comb begin
      ptr_next_s = '0;
      if (winner_s == PW'(N - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = winner_s + PW'(1);
      end
      y_next_s = din[int'(winner_s)*W +: W];
   end

   // One-hot grant, suppressed during stalls and while reset is asserted.
   always_comb begin
      grant_s = '0;
      if (load_en_s && any_req_s && !rst) begin
         grant_s[winner_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   // Output stage and arbitration pointer; data may drain and reload on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_r     <= '0;
         valid_r <= 1'b0;
         ptr_r   <= '0;
      end else if (load_en_s) begin
         if (any_req_s) begin
            y_r     <= y_next_s;
            valid_r <= 1'b1;
            if (RR != 0) begin
               ptr_r <= ptr_next_s;
            end else begin
               ptr_r <= '0;
            end
         end else begin
            valid_r <= 1'b0;
         end
      end
   end

   assign grant = grant_s;
   assign y     = y_r;
   assign valid = valid_r;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench: a round-robin and a fixed-priority instance share all inputs
// and are checked against hand-computed values.
module tb_bus_mux_arb;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] din;
   logic           ready;
   logic [N-1:0]   grant_rr, grant_fp;
   logic [W-1:0]   y_rr, y_fp;
   logic           valid_rr, valid_fp;
   int             total = 0;
   int             bad   = 0;

   bus_mux_arb #(.N(N), .W(W), .RR(1)) dut_rr (
      .clk(clk), .rst(rst), .req(req), .din(din),
      .grant(grant_rr), .y(y_rr), .valid(valid_rr), .ready(ready));

   bus_mux_arb #(.N(N), .W(W), .RR(0)) dut_fp (
      .clk(clk), .rst(rst), .req(req), .din(din),
      .grant(grant_fp), .y(y_fp), .valid(valid_fp), .ready(ready));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset with all requests pending
      rst   = 1'b1;
      req   = 4'b1111;
      ready = 1'b1;
      din   = {8'h13, 8'h12, 8'h11, 8'h10};
      tick();
      tick();
      chk("rst_y_rr", 32'(y_rr), 32'h0);
      chk("rst_valid_rr", 32'(valid_rr), 32'h0);
      chk("rst_grant_rr", 32'(grant_rr), 32'h0);
      chk("rst_grant_fp", 32'(grant_fp), 32'h0);
      chk("rst_valid_fp", 32'(valid_fp), 32'h0);
      rst = 1'b0;
      #1;
      chk("first_grant_rr", 32'(grant_rr), 32'h1);
      chk("first_grant_fp", 32'(grant_fp), 32'h1);
      tick();

      // Round-robin fairness and fixed-priority hold with all requests
      for (int k = 0; k < 8; k++) begin
         chk("rr_fair_y", 32'(y_rr), 32'h10 + 32'(k % 4));
         chk("rr_fair_valid", 32'(valid_rr), 32'h1);
         chk("rr_fair_grant", 32'(grant_rr), 32'h1 << ((k + 1) % 4));
         chk("fp_all_y", 32'(y_fp), 32'h10);
         tick();
      end

      // Single channel request
      req = 4'b0100;
      din = {8'h00, 8'hA5, 8'h00, 8'h00};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("single_grant_rr", 32'(grant_rr), 32'h4);
      chk("single_grant_fp", 32'(grant_fp), 32'h4);
      tick();
      chk("single_y_rr", 32'(y_rr), 32'hA5);
      chk("single_valid_rr", 32'(valid_rr), 32'h1);
      chk("single_y_fp", 32'(y_fp), 32'hA5);
      req = 4'b1111;
      din = {8'h23, 8'h22, 8'h21, 8'h20};
      #1;
      chk("rr_resume_ch3", 32'(grant_rr), 32'h8);
      chk("fp_lowest", 32'(grant_fp), 32'h1);
      tick();
      chk("rr_resume_y", 32'(y_rr), 32'h23);
      chk("fp_lowest_y", 32'(y_fp), 32'h20);

      // Fixed priority starvation of channel 3
      req = 4'b1010;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("fp_starve_grant", 32'(grant_fp), 32'h2);
         tick();
         chk("fp_starve_y", 32'(y_fp), 32'h21);
      end

      // Backpressure
      req = 4'b0001;
      din = {8'h00, 8'h00, 8'h00, 8'h3C};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("bp_cap_y", 32'(y_rr), 32'h3C);
      ready = 1'b0;
      din[7:0] = 8'h4D;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_grant_rr", 32'(grant_rr), 32'h0);
         chk("bp_grant_fp", 32'(grant_fp), 32'h0);
         tick();
         chk("bp_y_rr", 32'(y_rr), 32'h3C);
         chk("bp_valid_rr", 32'(valid_rr), 32'h1);
         chk("bp_y_fp", 32'(y_fp), 32'h3C);
      end
      ready = 1'b1;
      #1;
      chk("bp_release_grant", 32'(grant_rr), 32'h1);
      tick();
      chk("bp_next_y", 32'(y_rr), 32'h4D);
      chk("bp_next_valid", 32'(valid_rr), 32'h1);
      chk("bp_next_y_fp", 32'(y_fp), 32'h4D);

      // Idle: valid falls, y holds
      req = 4'b0000;
      #1;
      chk("idle_grant", 32'(grant_rr), 32'h0);
      tick();
      chk("idle_valid", 32'(valid_rr), 32'h0);
      chk("idle_y", 32'(y_rr), 32'h4D);
      chk("idle_valid_fp", 32'(valid_fp), 32'h0);
      #1;
      ready = 1'b0;
      tick();
      chk("idle_ready_ignored", 32'(y_rr), 32'h4D);
      ready = 1'b1;

      // Reset mid-stream with a pending word and a non-zero pointer
      req = 4'b0001;
      din = {8'h00, 8'h00, 8'h00, 8'h5E};
      tick();
      chk("mid_cap_y", 32'(y_rr), 32'h5E);
      chk("mid_cap_valid", 32'(valid_rr), 32'h1);
      ready = 1'b0;
      req   = 4'b1111;
      din   = {8'h13, 8'h12, 8'h11, 8'h10};
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(valid_rr), 32'h0);
      chk("mid_rst_y", 32'(y_rr), 32'h0);
      chk("mid_rst_grant", 32'(grant_rr), 32'h0);
      rst   = 1'b0;
      ready = 1'b1;
      #1;
      chk("mid_rst_ptr0", 32'(grant_rr), 32'h1);
      tick();
      chk("mid_rst_y_after", 32'(y_rr), 32'h10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
